// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_DVD_DEF = 6;
   localparam int N_DVS_DEF = 3;

   // Quotient reported for a zero divisor: all ones.
   localparam logic [N_DVD_DEF-1:0] DBZ_Q = '1;

endpackage

// File: rtl/seq_div_63_if.sv
// rtl/seq_div_63_if.sv - start/done request and result bundle for the divider
interface seq_div_63_if #(
   parameter int N_DVD = 6,
   parameter int N_DVS = 3
);
   logic             start;
   logic [N_DVD-1:0] dividend;
   logic [N_DVS-1:0] divisor;
   logic             ready;
   logic             done;
   logic [N_DVD-1:0] q;
   logic [N_DVS-1:0] r;
   logic             dbz;

   modport master (
      output start, dividend, divisor,
      input  ready, done, q, r, dbz
   );

   modport slave (
      input  start, dividend, divisor,
      output ready, done, q, r, dbz
   );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
   parameter int N_DVS = 3
) (
   input  logic [N_DVS:0]   rem,
   input  logic             bit_in,
   input  logic [N_DVS-1:0] divisor,
   output logic [N_DVS:0]   rem_nx,
   output logic             q_bit
);

   logic [N_DVS+1:0] shifted;
   logic [N_DVS:0]   diff;

   // Shift in the next dividend bit, then subtract the divisor if it fits.
   // diff is only kept when shifted >= divisor, so dropping its top bit is safe.
   always_comb begin
      shifted = {rem, bit_in};
      diff    = shifted[N_DVS:0] - {1'b0, divisor};
      q_bit   = (shifted >= {2'b00, divisor});
      rem_nx  = q_bit ? diff : shifted[N_DVS:0];
   end

endmodule

// File: rtl/seq_div_63.sv
// rtl/seq_div_63.sv - multi-cycle unsigned restoring divider with start/done handshake
module seq_div_63
   import div_pkg::*;
#(
   parameter int N_DVD = N_DVD_DEF,
   parameter int N_DVS = N_DVS_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   seq_div_63_if.slave  bus
);

   localparam int CNT_W = (N_DVD > 1) ? $clog2(N_DVD) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_DVD - 1);

   state_t           state;
   state_t           state_nx;
   logic [N_DVD-1:0] qsh;
   logic [N_DVS:0]   rem;
   logic [N_DVS-1:0] dvs;
   logic [CNT_W-1:0] cnt;
   logic [N_DVD-1:0] q_r;
   logic [N_DVS-1:0] r_r;
   logic             dbz_r;

   logic [N_DVS:0]   rem_nx;
   logic             q_bit;
   logic             last_step;

   assign last_step = (cnt == LAST_STEP);

   div_step #(.N_DVS(N_DVS)) u_step (
      .rem     (rem),
      .bit_in  (qsh[N_DVD-1]),
      .divisor (dvs),
      .rem_nx  (rem_nx),
      .q_bit   (q_bit)
   );

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state: zero divisor short-circuits straight to DONE.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = (bus.divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_step) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: capture operands on accept, one step per RUN cycle, latch result on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qsh   <= '0;
         rem   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         q_r   <= '0;
         r_r   <= '0;
         dbz_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.divisor == '0) begin
                     q_r   <= '1;
                     r_r   <= '0;
                     dbz_r <= 1'b1;
                  end else begin
                     qsh   <= bus.dividend;
                     rem   <= '0;
                     dvs   <= bus.divisor;
                     cnt   <= '0;
                     dbz_r <= 1'b0;
                  end
               end
            end
            RUN: begin
               qsh <= {qsh[N_DVD-2:0], q_bit};
               rem <= rem_nx;
               cnt <= cnt + 1'b1;
               if (last_step) begin
                  q_r <= {qsh[N_DVD-2:0], q_bit};
                  r_r <= rem_nx[N_DVS-1:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready = (state == IDLE);
   assign bus.done  = (state == DONE);
   assign bus.q     = q_r;
   assign bus.r     = r_r;
   assign bus.dbz   = dbz_r;

endmodule

// File: tb/tb_seq_div_63.sv
// tb/tb_seq_div_63.sv - self-checking bench for seq_div_63
module tb_seq_div_63;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   seq_div_63_if #(.N_DVD(6), .N_DVS(3)) bus ();

   seq_div_63 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer division, zero divisor gives all-ones quotient.
   function automatic void ref_div(input int a, input int b,
                                   output int eq, output int er, output int ed, output int elat);
      if (b == 0) begin
         eq = 63; er = 0; ed = 1; elat = 1;
      end else begin
         eq = a / b; er = a % b; ed = 0; elat = 7;
      end
   endfunction

   // Issue one request and observe it through done. scramble changes inputs after acceptance.
   task automatic run_op(input int a, input int b, input bit scramble,
                         output int lat, output int gq, output int gr, output int gd,
                         output bit ready_hi, output bit dbl);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 6'(a);
      bus.divisor  = 3'(b);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (scramble) begin
         bus.dividend = 6'($urandom_range(0, 63));
         bus.divisor  = 3'($urandom_range(0, 7));
      end
      lat      = 0;
      ready_hi = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.ready) ready_hi = 1'b1;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      gq = int'(bus.q);
      gr = int'(bus.r);
      gd = int'(bus.dbz);
      @(negedge clk);
      dbl = bus.done;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clk);
      tests++;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.q !== 6'd0 || bus.r !== 3'd0 || bus.dbz !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: ready=%b done=%b q=%0d r=%0d dbz=%b, need ready=1 done=0 q=0 r=0 dbz=0",
                  bus.ready, bus.done, bus.q, bus.r, bus.dbz);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: ready=%b done=%b, need 1/0", bus.ready, bus.done);
      end
   endtask

   task automatic test_single();
      int lat, gq, gr, gd;
      bit rh, dbl;
      run_op(42, 6, 1'b0, lat, gq, gr, gd, rh, dbl);
      tests++;
      if (lat !== 7) begin
         fails++;
         $display("FAIL single_latency: got %0d cycles, need 7", lat);
      end
      tests++;
      if (gq !== 7 || gr !== 0 || gd !== 0) begin
         fails++;
         $display("FAIL single_result: q=%0d r=%0d dbz=%0d, need 7 0 0", gq, gr, gd);
      end
      tests++;
      if (rh !== 1'b0 || dbl !== 1'b0) begin
         fails++;
         $display("FAIL single_handshake: ready_seen=%b done_twice=%b, need 0 0", rh, dbl);
      end
   endtask

   task automatic test_boundary();
      int da[3] = '{63, 5, 0};
      int dv[3] = '{1, 7, 3};
      int lat, gq, gr, gd, eq, er, ed, el;
      bit rh, dbl;
      for (int i = 0; i < 3; i++) begin
         run_op(da[i], dv[i], 1'b0, lat, gq, gr, gd, rh, dbl);
         ref_div(da[i], dv[i], eq, er, ed, el);
         tests++;
         if (gq !== eq || gr !== er || gd !== ed || lat !== el) begin
            fails++;
            $display("FAIL boundary %0d/%0d: q=%0d r=%0d dbz=%0d lat=%0d, need %0d %0d %0d %0d",
                     da[i], dv[i], gq, gr, gd, lat, eq, er, ed, el);
         end
      end
   endtask

   task automatic test_dbz();
      int lat, gq, gr, gd;
      bit rh, dbl;
      run_op(13, 0, 1'b0, lat, gq, gr, gd, rh, dbl);
      tests++;
      if (lat !== 1 || gq !== 63 || gr !== 0 || gd !== 1) begin
         fails++;
         $display("FAIL dbz: lat=%0d q=%0d r=%0d dbz=%0d, need 1 63 0 1", lat, gq, gr, gd);
      end
      tests++;
      if (dbl !== 1'b0) begin
         fails++;
         $display("FAIL dbz_single_done: done_twice=%b, need 0", dbl);
      end
      run_op(12, 4, 1'b0, lat, gq, gr, gd, rh, dbl);
      tests++;
      if (lat !== 7 || gq !== 3 || gr !== 0 || gd !== 0) begin
         fails++;
         $display("FAIL dbz_clear: lat=%0d q=%0d r=%0d dbz=%0d, need 7 3 0 0", lat, gq, gr, gd);
      end
   endtask

   task automatic test_busy();
      int pulses = 0;
      int gq = -1;
      int gr = -1;
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 6'd20; bus.divisor = 3'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 6'd50; bus.divisor = 3'd5;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done) begin
            pulses++;
            gq = int'(bus.q);
            gr = int'(bus.r);
         end
      end
      tests++;
      if (pulses !== 1 || gq !== 6 || gr !== 2) begin
         fails++;
         $display("FAIL busy_ignore: pulses=%0d q=%0d r=%0d, need 1 6 2", pulses, gq, gr);
      end
   endtask

   task automatic test_input_change();
      int a, b, lat, gq, gr, gd, eq, er, ed, el;
      bit rh, dbl;
      for (int i = 0; i < 20; i++) begin
         a = $urandom_range(0, 63);
         b = $urandom_range(0, 7);
         run_op(a, b, 1'b1, lat, gq, gr, gd, rh, dbl);
         ref_div(a, b, eq, er, ed, el);
         tests++;
         if (gq !== eq || gr !== er || gd !== ed || lat !== el) begin
            fails++;
            $display("FAIL input_change %0d/%0d: q=%0d r=%0d dbz=%0d lat=%0d, need %0d %0d %0d %0d",
                     a, b, gq, gr, gd, lat, eq, er, ed, el);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat, gq, gr, gd;
      bit rh, dbl;
      run_op(29, 5, 1'b0, lat, gq, gr, gd, rh, dbl);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 6'd45; bus.divisor = 3'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.q !== 6'd0 || bus.r !== 3'd0 || bus.dbz !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: q=%0d r=%0d dbz=%b ready=%b done=%b, need 0 0 0 1 0",
                  bus.q, bus.r, bus.dbz, bus.ready, bus.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(45, 7, 1'b0, lat, gq, gr, gd, rh, dbl);
      tests++;
      if (lat !== 7 || gq !== 6 || gr !== 3 || gd !== 0) begin
         fails++;
         $display("FAIL reset_recover: lat=%0d q=%0d r=%0d dbz=%0d, need 7 6 3 0", lat, gq, gr, gd);
      end
   endtask

   task automatic test_sweep();
      int lat, gq, gr, gd, eq, er, ed, el;
      bit rh, dbl;
      for (int a = 0; a < 64; a++) begin
         for (int b = 0; b < 8; b++) begin
            run_op(a, b, 1'b0, lat, gq, gr, gd, rh, dbl);
            ref_div(a, b, eq, er, ed, el);
            tests++;
            if (gq !== eq || gr !== er || gd !== ed || lat !== el || rh !== 1'b0 || dbl !== 1'b0) begin
               fails++;
               $display("FAIL sweep %0d/%0d: q=%0d r=%0d dbz=%0d lat=%0d ready_seen=%b done_twice=%b, need %0d %0d %0d %0d 0 0",
                        a, b, gq, gr, gd, lat, rh, dbl, eq, er, ed, el);
            end
         end
      end
   endtask

   task automatic test_random();
      int a, b, lat, gq, gr, gd, eq, er, ed, el;
      bit rh, dbl;
      for (int i = 0; i < 100; i++) begin
         a = $urandom_range(0, 63);
         b = $urandom_range(0, 7);
         run_op(a, b, 1'b0, lat, gq, gr, gd, rh, dbl);
         ref_div(a, b, eq, er, ed, el);
         tests++;
         if (gq !== eq || gr !== er || gd !== ed || lat !== el) begin
            fails++;
            $display("FAIL random %0d/%0d: q=%0d r=%0d dbz=%0d lat=%0d, need %0d %0d %0d %0d",
                     a, b, gq, gr, gd, lat, eq, er, ed, el);
         end
      end
   endtask

   task automatic test_roundtrip();
      int p, lat, gq, gr, gd;
      bit rh, dbl;
      for (int x = 0; x < 8; x++) begin
         for (int y = 1; y < 8; y++) begin
            p = x * y;
            run_op(p, y, 1'b0, lat, gq, gr, gd, rh, dbl);
            tests++;
            if (gq !== x || gr !== 0 || gd !== 0) begin
               fails++;
               $display("FAIL roundtrip %0d*%0d=%0d: q=%0d r=%0d dbz=%0d, need %0d 0 0",
                        x, y, p, gq, gr, gd, x);
            end
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_boundary();
      test_dbz();
      test_busy();
      test_input_change();
      test_reset_mid();
      test_sweep();
      test_random();
      test_roundtrip();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
